dp_update_sched: RTL
====================

// Module: dp_update_sched
// PURPOSE
//  Update scheduler for the two-bit direction predictor (BHT + tagged BTB), which has a single write port.
//  Arbitrates two execute-stage branch resolution ports round-robin onto that port.
//  Sequences a full table flush, one index per cycle.
//  Sits between the execute stage(s) and the predictor's in_exe_* update interface.
// PARAMETERS
//  BHT_ENTERIES     128  BHT depth; power of 2; IDX_W = clog2(BHT_ENTERIES).
//  BTB_ENTERIES     32   BTB depth; power of 2; <= BHT_ENTERIES.
//  INSTR_SIZE_BYTE  4    PC/offset width = INSTR_SIZE_BYTE*8 (AW).
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      async active-low reset
//  in_req0_valid    in   1      execute port 0: resolved branch valid
//  in_req0_pc       in   AW     port 0 branch PC
//  in_req0_taken    in   1      port 0 resolved direction
//  in_req0_offset   in   AW     port 0 target offset
//  out_req0_ready   out  1      port 0 accepted when valid && ready
//  in_req1_*        in   -      port 1, same fields/widths as port 0
//  out_req1_ready   out  1      port 1 ready
//  in_flush         in   1      1-cycle pulse: start table flush
//  out_upd_valid    out  1      drives predictor update (predictor in_exe_nop = !out_upd_valid)
//  out_upd_pc       out  AW     update PC
//  out_upd_taken    out  1      update direction
//  out_upd_offset   out  AW     update target offset
//  out_flush_valid  out  1      clear BHT[idx]; also BTB[idx] when idx < BTB_ENTERIES
//  out_flush_idx    out  IDX_W  index to clear
//  out_flush_done   out  1      1-cycle pulse after last index is cleared
//  out_busy         out  1      high while in FLUSH state
// BEHAVIOUR
//  Clock and reset
//   - clk/rst_n: single clock, asynchronous active-low reset.
//   - Reset: every output 0, state=IDLE, rr_ptr=0 (port 0 has priority).
//   - Reset mid-flush aborts the flush; out_flush_done is not pulsed.
//  FSM
//   - IDLE -> FLUSH on in_flush (sampled in IDLE only).
//   - FLUSH: idx counts 0..BHT_ENTERIES-1, one per cycle. After the last index, -> IDLE with out_flush_done=1 for that cycle.
//   - in_flush during FLUSH is ignored; it does not restart the walk.
//  Ready
//   - Combinational; may depend on in_reqX_valid. Requesters must not make valid depend on ready.
//   - Both ready=0 in FLUSH, and in IDLE in any cycle where in_flush=1 (flush wins over requests).
//   - IDLE with one valid requester: that requester gets ready=1.
//   - Both valid: the port named by rr_ptr gets ready=1, the other 0. rr_ptr flips to the non-granted port after every 2-way grant.
//   - Single-requester grant: rr_ptr := other port.
//   - Accepted PC/offset values are not modified. Held requests keep all fields stable until accepted.
//  Output timing
//   - Granted request appears on out_upd_* the next cycle (latency 1). out_upd_valid=1 for exactly 1 cycle per accept.
//   - No grant: out_upd_valid=0; out_upd_pc/taken/offset hold their last values.
//   - out_flush_valid/out_flush_idx registered: first clear (idx 0) appears the cycle after in_flush. out_flush_valid and out_upd_valid are never both 1.
//  Other
//   - out_busy = (state==FLUSH).
//   - No same-index merging: two updates to one PC are issued in grant order on consecutive cycles.
// CONFIGURATION
//  DP_UPD_STATS_EN
//   - Defined: adds out_stat_grant0, out_stat_grant1 and out_stat_stall, each 32-bit, saturating at 32'hFFFF_FFFF.
//   - Grant counters increment per accept on their port.
//   - Stall counter increments once per cycle in which any valid requester has ready=0.
//   - All three are cleared by reset only, not by flush.
//   - Undefined: the three ports and their counters do not exist.
// STRUCTURE
//  dp_pkg
//   - localparams IDX_W and AW.
//   - State encoding: ST_IDLE=1'b0, ST_FLUSH=1'b1.
//   - Update-record field layout {pc, taken, offset}.
//  Sub-module dp_rr_arb2
//   - 2-way round-robin arbiter: valid[1:0] and rr_ptr in, gnt[1:0] out.
//   - Pointer update stays in this block.
// TESTING
//  T1 Reset:
//   - Drive rst_n=0 with requests active -> all outputs 0.
//   - First grant after release goes to port 0.
//  T2 Single port:
//   - req0 pc=32'h0000_0104, taken=1, offset=32'h40 -> ready0=1.
//   - Next cycle: out_upd_valid=1, pc=0x104, taken=1, offset=0x40.
//  T3 Contention:
//   - Both ports valid for 4 cycles -> grants alternate 0,1,0,1.
//   - Loser's ready=0 each cycle; 4 updates in grant order.
//  T4 Flush:
//   - Pulse in_flush -> out_flush_idx runs 0..127 over 128 consecutive cycles.
//   - out_busy=1 throughout; out_flush_done pulses at idx 127.
//   - Requests stall (ready=0), then resume on the next cycle.
//  T5 Collisions:
//   - in_flush in the same cycle as req0 -> no grant; flush starts.
//   - in_flush at idx 50 -> ignored.
//   - rst_n=0 at idx 60 -> IDLE, no done pulse.
//  T6 DP_UPD_STATS_EN:
//   - 3 port-0 grants, 2 port-1 grants, 4 stall cycles -> stat_grant0=3, stat_grant1=2, stat_stall=4.
//   - Preload 32'hFFFF_FFFF -> counters stay saturated.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and default geometry for the direction-predictor update scheduler.
// Optional build macro: DP_UPD_STATS_EN (grant/stall counters on the top).
package dp_pkg;

  localparam int IDX_W = 7;
  localparam int AW    = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          taken;
    logic [AW-1:0] offset;
  } upd_rec_t;

endpackage

// File: rtl/dp_rr_arb2.sv
// Two-way round-robin arbiter; owns its rotating priority pointer.
// Pointer moves to the port that was not granted after every grant.
module dp_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    unique case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (gnt[0]) begin
      rr_ptr <= 1'b1;
    end else if (gnt[1]) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/dp_update_sched.sv
// Update scheduler: arbitrates two branch-resolution ports onto the
// predictor write port and walks a table flush. Macro: DP_UPD_STATS_EN.
module dp_update_sched
  import dp_pkg::*;
#(
  parameter int BHT_ENTERIES    = 1 << IDX_W,
  parameter int BTB_ENTERIES    = 32,
  parameter int INSTR_SIZE_BYTE = AW / 8,
  localparam int IW = $clog2((BTB_ENTERIES > BHT_ENTERIES) ?
                             BTB_ENTERIES : BHT_ENTERIES),
  localparam int UW = INSTR_SIZE_BYTE * 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_req0_valid,
  input  logic [UW-1:0] in_req0_pc,
  input  logic          in_req0_taken,
  input  logic [UW-1:0] in_req0_offset,
  output logic          out_req0_ready,
  input  logic          in_req1_valid,
  input  logic [UW-1:0] in_req1_pc,
  input  logic          in_req1_taken,
  input  logic [UW-1:0] in_req1_offset,
  output logic          out_req1_ready,
  input  logic          in_flush,
  output logic          out_upd_valid,
  output logic [UW-1:0] out_upd_pc,
  output logic          out_upd_taken,
  output logic [UW-1:0] out_upd_offset,
  output logic          out_flush_valid,
  output logic [IW-1:0] out_flush_idx,
  output logic          out_flush_done,
`ifdef DP_UPD_STATS_EN
  output logic [31:0]   out_stat_grant0,
  output logic [31:0]   out_stat_grant1,
  output logic [31:0]   out_stat_stall,
`endif
  output logic          out_busy
);

  localparam logic [IW-1:0] LAST = IW'(BHT_ENTERIES - 1);

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          done_nx;
  logic          block;
  logic [1:0]    vld, gnt;

  // A flush request, the walk itself and reset all pre-empt updates
  assign block = !rst_n || (state == ST_FLUSH) || in_flush;
  assign vld   = {in_req1_valid, in_req0_valid} & {2{!block}};

  dp_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (vld),
    .gnt   (gnt)
  );

  assign out_req0_ready  = gnt[0];
  assign out_req1_ready  = gnt[1];
  assign out_busy        = (state == ST_FLUSH);
  assign out_flush_valid = (state == ST_FLUSH);
  assign out_flush_idx   = idx;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    done_nx  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_flush) begin
          state_nx = ST_FLUSH;
          idx_nx   = '0;
        end
      end
      ST_FLUSH: begin
        if (idx == LAST) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      out_flush_done <= 1'b0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      out_flush_done <= done_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_upd_valid  <= 1'b0;
      out_upd_pc     <= '0;
      out_upd_taken  <= 1'b0;
      out_upd_offset <= '0;
    end else begin
      out_upd_valid <= |gnt;
      if (gnt[0]) begin
        out_upd_pc     <= in_req0_pc;
        out_upd_taken  <= in_req0_taken;
        out_upd_offset <= in_req0_offset;
      end else if (gnt[1]) begin
        out_upd_pc     <= in_req1_pc;
        out_upd_taken  <= in_req1_taken;
        out_upd_offset <= in_req1_offset;
      end
    end
  end

`ifdef DP_UPD_STATS_EN
  logic stall;

  assign stall = (in_req0_valid && !gnt[0]) ||
                 (in_req1_valid && !gnt[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stat_grant0 <= '0;
      out_stat_grant1 <= '0;
      out_stat_stall  <= '0;
    end else begin
      if (gnt[0] && out_stat_grant0 != 32'hFFFF_FFFF)
        out_stat_grant0 <= out_stat_grant0 + 32'd1;
      if (gnt[1] && out_stat_grant1 != 32'hFFFF_FFFF)
        out_stat_grant1 <= out_stat_grant1 + 32'd1;
      if (stall && out_stat_stall != 32'hFFFF_FFFF)
        out_stat_stall <= out_stat_stall + 32'd1;
    end
  end
`endif

endmodule
